// File: rtl/uvmt_mem_st_prot_chkr.sv
// Memory-channel protocol checker.
// Each channel is watched for three things: a request that changes or drops
// while it waits for a grant, the balance of read requests against read
// responses, and responses that take too long to arrive.
// Violations produce one-cycle registered pulses. They also feed a sticky
// error flag and a saturating error counter that cover all channels.
module uvmt_mem_st_prot_chkr #(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_OUTS = 4,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH-1:0]        gnt_i,
    input  logic [NUM_CH-1:0]        we_i,
    input  logic [NUM_CH*ADDR_W-1:0] addr_i,
    input  logic [NUM_CH*DATA_W-1:0] wdata_i,
    input  logic [NUM_CH-1:0]        rvalid_i,
    output logic [NUM_CH-1:0]        err_stable_o,
    output logic [NUM_CH-1:0]        err_unf_o,
    output logic [NUM_CH-1:0]        err_ovf_o,
    output logic [NUM_CH-1:0]        err_tmo_o,
    output logic [NUM_CH*8-1:0]      outs_cnt_o,
    output logic                     err_any_o,
    output logic [CNT_W-1:0]         err_count_o
);

    localparam logic [7:0]       MAX_C = 8'(MAX_OUTS);
    localparam logic [15:0]      TMO_C = 16'(TIMEOUT);
    localparam logic [CNT_W+7:0] SAT_C = {8'd0, {CNT_W{1'b1}}};

    logic [NUM_CH-1:0] err_stable_d, err_unf_d, err_ovf_d, err_tmo_d;
    logic [NUM_CH-1:0] err_stable_q, err_unf_q, err_ovf_q, err_tmo_q;
    logic [4*NUM_CH-1:0] pulse_d;
    logic [7:0]          pulse_n;
    logic [CNT_W-1:0]    err_count_d, err_count_q, count_base;
    logic [CNT_W+7:0]    count_sum;
    logic                err_any_d, err_any_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic              pend_q, cap_we_q;
        logic [ADDR_W-1:0] cap_addr_q, addr_c;
        logic [DATA_W-1:0] cap_wdata_q, wdata_c;
        logic [7:0]        cnt_q, cnt_d;
        logic [15:0]       tmr_q, tmr_d;
        logic              rd_acc, stb_viol, unf_viol, ovf_viol, tmo_viol;

        assign addr_c  = addr_i[c*ADDR_W +: ADDR_W];
        assign wdata_c = wdata_i[c*DATA_W +: DATA_W];
        assign rd_acc  = req_i[c] & gnt_i[c] & ~we_i[c];

        // Write data is compared only when the captured request is a write.
        assign stb_viol = pend_q & (~req_i[c] | (we_i[c] != cap_we_q) |
                                    (addr_c != cap_addr_q) |
                                    (cap_we_q & (wdata_c != cap_wdata_q)));

        // Outstanding-read count. A read and a response in the same cycle cancel out.
        always_comb begin
            cnt_d    = cnt_q;
            unf_viol = 1'b0;
            ovf_viol = 1'b0;
            if (rd_acc && !rvalid_i[c]) begin
                if (cnt_q == MAX_C) ovf_viol = 1'b1;
                else                cnt_d    = cnt_q + 8'd1;
            end else if (!rd_acc && rvalid_i[c]) begin
                if (cnt_q == 8'd0)  unf_viol = 1'b1;
                else                cnt_d    = cnt_q - 8'd1;
            end
        end

        // Response-silence timer. It fires once on reaching TIMEOUT and then parks there.
        always_comb begin
            tmr_d    = tmr_q;
            tmo_viol = 1'b0;
            if (rvalid_i[c] || cnt_q == 8'd0) begin
                tmr_d = 16'd0;
            end else if (tmr_q != TMO_C) begin
                tmr_d    = tmr_q + 16'd1;
                tmo_viol = (tmr_d == TMO_C);
            end
        end

        // Per-channel tracking state. It keeps updating when checking is disabled.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                pend_q      <= 1'b0;
                cap_we_q    <= 1'b0;
                cap_addr_q  <= '0;
                cap_wdata_q <= '0;
                cnt_q       <= '0;
                tmr_q       <= '0;
            end else begin
                pend_q      <= req_i[c] & ~gnt_i[c];
                cap_we_q    <= we_i[c];
                cap_addr_q  <= addr_c;
                cap_wdata_q <= wdata_c;
                cnt_q       <= cnt_d;
                tmr_q       <= tmr_d;
            end
        end

        assign err_stable_d[c]       = enable_i & stb_viol;
        assign err_unf_d[c]          = enable_i & unf_viol;
        assign err_ovf_d[c]          = enable_i & ovf_viol;
        assign err_tmo_d[c]          = enable_i & tmo_viol;
        assign outs_cnt_o[c*8 +: 8]  = cnt_q;
    end

    assign pulse_d = {err_stable_d, err_unf_d, err_ovf_d, err_tmo_d};
    assign pulse_n = 8'($countones(pulse_d));

    // The counter and sticky flag are updated from the same next pulses, so they
    // move in the same cycle as the pulses. A simultaneous clear keeps only
    // that cycle's errors.
    always_comb begin
        count_base  = clear_i ? '0 : err_count_q;
        count_sum   = {8'd0, count_base} + {{CNT_W{1'b0}}, pulse_n};
        err_count_d = (count_sum > SAT_C) ? {CNT_W{1'b1}} : count_sum[CNT_W-1:0];
        err_any_d   = (err_any_q & ~clear_i) | (|pulse_d);
    end

    // Registered error pulses and aggregate status.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_stable_q <= '0;
            err_unf_q    <= '0;
            err_ovf_q    <= '0;
            err_tmo_q    <= '0;
            err_count_q  <= '0;
            err_any_q    <= 1'b0;
        end else begin
            err_stable_q <= err_stable_d;
            err_unf_q    <= err_unf_d;
            err_ovf_q    <= err_ovf_d;
            err_tmo_q    <= err_tmo_d;
            err_count_q  <= err_count_d;
            err_any_q    <= err_any_d;
        end
    end

    assign err_stable_o = err_stable_q;
    assign err_unf_o    = err_unf_q;
    assign err_ovf_o    = err_ovf_q;
    assign err_tmo_o    = err_tmo_q;
    assign err_count_o  = err_count_q;
    assign err_any_o    = err_any_q;

endmodule

// File: tb/tb_uvmt_mem_st_prot_chkr.sv
// Testbench for uvmt_mem_st_prot_chkr.
// The DUT's outputs are compared against a transaction-level model of the
// checker's rules.
module tb_uvmt_mem_st_prot_chkr;

    localparam int NCH  = 2;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int MO   = 4;
    localparam int TO   = 8;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk_i = 1'b0;
    logic            reset_i, enable_i, clear_i;
    logic [NCH-1:0]  req_i, gnt_i, we_i, rvalid_i;
    logic [NCH*AW-1:0] addr_i;
    logic [NCH*DW-1:0] wdata_i;
    logic [NCH-1:0]  err_stable_o, err_unf_o, err_ovf_o, err_tmo_o;
    logic [NCH*8-1:0] outs_cnt_o;
    logic            err_any_o;
    logic [CW-1:0]   err_count_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int              m_cnt  [NCH];
    int              m_age  [NCH];
    bit              m_pend [NCH];
    bit              m_cwe  [NCH];
    logic [AW-1:0]   m_caddr[NCH];
    logic [DW-1:0]   m_cwd  [NCH];
    int              m_ecount;
    bit              m_any;
    logic [NCH-1:0]  e_stb, e_unf, e_ovf, e_tmo;

    uvmt_mem_st_prot_chkr #(
        .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW),
        .MAX_OUTS(MO), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .clear_i(clear_i),
        .req_i(req_i), .gnt_i(gnt_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rvalid_i(rvalid_i),
        .err_stable_o(err_stable_o), .err_unf_o(err_unf_o),
        .err_ovf_o(err_ovf_o), .err_tmo_o(err_tmo_o),
        .outs_cnt_o(outs_cnt_o), .err_any_o(err_any_o), .err_count_o(err_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_age[c] = 0; m_pend[c] = 0; m_cwe[c] = 0;
            m_caddr[c] = '0; m_cwd[c] = '0;
        end
        m_ecount = 0;
        m_any    = 0;
    endtask

    task automatic idle();
        req_i = '0; gnt_i = '0; we_i = '0; rvalid_i = '0;
        addr_i = '0; wdata_i = '0; enable_i = 1'b1; clear_i = 1'b0;
    endtask

    task automatic set_ch(input int c, input bit rq, input bit g, input bit w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d, input bit rv);
        req_i[c] = rq; gnt_i[c] = g; we_i[c] = w; rvalid_i[c] = rv;
        addr_i[c*AW +: AW]  = a;
        wdata_i[c*DW +: DW] = d;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_stable"}, err_stable_o, 0);
        check_val({tag, "_unf"},    err_unf_o,    0);
        check_val({tag, "_ovf"},    err_ovf_o,    0);
        check_val({tag, "_tmo"},    err_tmo_o,    0);
        check_val({tag, "_outs"},   outs_cnt_o,   0);
        check_val({tag, "_any"},    err_any_o,    0);
        check_val({tag, "_count"},  err_count_o,  0);
    endtask

    // Apply the current inputs for one cycle, then compare against the model.
    task automatic step();
        int n;
        n = 0;
        for (int c = 0; c < NCH; c++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            bit rd, rv, v_stb, v_unf, v_ovf, v_tmo;
            a  = addr_i[c*AW +: AW];
            d  = wdata_i[c*DW +: DW];
            rv = rvalid_i[c];
            rd = req_i[c] && gnt_i[c] && !we_i[c];
            v_stb = m_pend[c] && (!req_i[c] || we_i[c] != m_cwe[c] || a != m_caddr[c] ||
                                  (m_cwe[c] && d != m_cwd[c]));
            v_unf = rv && !rd && m_cnt[c] == 0;
            v_ovf = rd && !rv && m_cnt[c] == MO;
            if (rv || m_cnt[c] == 0) m_age[c] = 0;
            else                     m_age[c]++;
            v_tmo = (m_age[c] == TO);
            if (rd && !rv && m_cnt[c] < MO)      m_cnt[c]++;
            else if (rv && !rd && m_cnt[c] > 0)  m_cnt[c]--;
            m_pend[c]  = req_i[c] && !gnt_i[c];
            m_cwe[c]   = we_i[c];
            m_caddr[c] = a;
            m_cwd[c]   = d;
            e_stb[c] = v_stb && enable_i;
            e_unf[c] = v_unf && enable_i;
            e_ovf[c] = v_ovf && enable_i;
            e_tmo[c] = v_tmo && enable_i;
            n += int'(e_stb[c]) + int'(e_unf[c]) + int'(e_ovf[c]) + int'(e_tmo[c]);
        end
        m_any    = (m_any && !clear_i) || (n > 0);
        m_ecount = (clear_i ? 0 : m_ecount) + n;
        if (m_ecount > CMAX) m_ecount = CMAX;
        @(posedge clk_i);
        #1;
        check_val("err_stable", err_stable_o, e_stb);
        check_val("err_unf",    err_unf_o,    e_unf);
        check_val("err_ovf",    err_ovf_o,    e_ovf);
        check_val("err_tmo",    err_tmo_o,    e_tmo);
        for (int c = 0; c < NCH; c++)
            check_val($sformatf("outs_cnt%0d", c), outs_cnt_o[c*8 +: 8], m_cnt[c]);
        check_val("err_any",    err_any_o,    m_any);
        check_val("err_count",  err_count_o,  m_ecount);
    endtask

    // Assert reset between clock edges and confirm that the outputs clear without a clock.
    task automatic async_reset(input string tag);
        #3 reset_i = 1'b1;
        #1 check_zero(tag);
        model_reset();
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    task automatic drive_rand();
        for (int c = 0; c < NCH; c++) begin
            if (m_pend[c] && $urandom_range(0, 7) != 0) begin
                set_ch(c, 1'b1, $urandom_range(0, 2) != 0, m_cwe[c], m_caddr[c], m_cwd[c],
                       $urandom_range(0, 2) == 0);
            end else begin
                set_ch(c, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                       $urandom_range(0, 1) == 1,
                       AW'($urandom_range(0, 1) * 4 + 'h100), DW'($urandom_range(0, 1)),
                       $urandom_range(0, 2) == 0);
            end
        end
        enable_i = $urandom_range(0, 7) != 0;
        clear_i  = $urandom_range(0, 31) == 0;
    endtask

    initial begin
        int tmo_seen;
        idle();
        reset_i = 1'b1;
        model_reset();
        #12 check_zero("reset");
        @(negedge clk_i);
        reset_i = 1'b0;

        // Single read on ch0, with the response arriving three cycles later.
        set_ch(0, 1, 1, 0, 16'h0040, 0, 0); step();
        check_val("rd_outs_1", outs_cnt_o[7:0], 1);
        idle(); step(); step();
        set_ch(0, 0, 0, 0, 0, 0, 1); step();
        check_val("rd_outs_0", outs_cnt_o[7:0], 0);
        check_val("rd_no_err", err_count_o, 0);

        // The ch1 address changes while the request waits for a grant.
        idle(); set_ch(1, 1, 0, 0, 16'h0100, 0, 0); step();
        set_ch(1, 1, 0, 0, 16'h0104, 0, 0); step();
        check_val("stb_pulse", err_stable_o, 2'b10);
        check_val("stb_count", err_count_o, 1);
        check_val("stb_any",   err_any_o, 1);
        idle(); step();

        // Five back-to-back reads on ch0: the fifth overflows.
        idle(); clear_i = 1'b1; step();
        for (int i = 0; i < 5; i++) begin
            idle(); set_ch(0, 1, 1, 0, 16'(i), 0, 0); step();
        end
        check_val("ovf_pulse", err_ovf_o, 2'b01);
        check_val("ovf_outs",  outs_cnt_o[7:0], MO);
        for (int i = 0; i < MO; i++) begin
            idle(); set_ch(0, 0, 0, 0, 0, 0, 1); step();
        end

        // One read stays unanswered for 20 cycles: exactly one timeout.
        idle(); clear_i = 1'b1; step();
        idle(); set_ch(0, 1, 1, 0, 16'h0200, 0, 0); step();
        tmo_seen = 0;
        for (int i = 0; i < 20; i++) begin
            idle(); step();
            if (err_tmo_o[0]) tmo_seen++;
        end
        check_val("tmo_once",  tmo_seen, 1);
        check_val("tmo_count", err_count_o, 1);
        idle(); set_ch(0, 0, 0, 0, 0, 0, 1); step();

        // Responses on both channels with nothing outstanding, with checking enabled and then disabled.
        idle(); clear_i = 1'b1; step();
        idle(); rvalid_i = 2'b11; step();
        check_val("unf_pulse", err_unf_o, 2'b11);
        check_val("unf_count", err_count_o, 2);
        idle(); rvalid_i = 2'b11; enable_i = 1'b0; step();
        check_val("unf_dis", err_unf_o, 2'b00);

        // The counter saturates, then a clear empties it.
        for (int i = 0; i < 40; i++) begin
            idle(); rvalid_i = 2'b11; step();
        end
        check_val("sat_count", err_count_o, CMAX);
        idle(); clear_i = 1'b1; step();
        check_val("clr_count", err_count_o, 0);
        check_val("clr_any",   err_any_o, 0);

        // A clear in the same cycle as new errors.
        idle(); rvalid_i = 2'b11; step();
        idle(); rvalid_i = 2'b11; clear_i = 1'b1; step();
        check_val("clr_err_count", err_count_o, 2);
        check_val("clr_err_any",   err_any_o, 1);

        // Reset in the middle of a burst, then a response right after release.
        idle(); set_ch(0, 1, 1, 0, 16'h0300, 0, 0); set_ch(1, 1, 0, 1, 16'h0104, 16'h5, 0); step();
        async_reset("mid_rst");
        idle(); set_ch(0, 0, 0, 0, 0, 0, 1); step();
        check_val("post_rst_unf", err_unf_o, 2'b01);

        // Randomized traffic, with an occasional asynchronous reset.
        for (int i = 0; i < 1500; i++) begin
            drive_rand();
            step();
            if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
